// File: rtl/regfile_pkg.sv
// Shared sizing and types for the CPU data-path register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;   // must equal $clog2(NUM_REGS)

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/register_read_port.sv
// One combinational read port: NUM_REGS:1 mux over the storage array,
// plus an optional write-through bypass (REGISTER_BYPASS_EN).
// Latency: zero cycles (purely combinational). Backpressure: none.
//
// Ports:
//   regs       full storage array, flattened (word i at regs[i])
//   addr       read index
//   data       selected word (or bypassed write data when enabled)
//   rst_n, write, write_addr, write_data
//              write-port view, present only when REGISTER_BYPASS_EN is defined
module register_read_port
    import regfile_pkg::*;
(
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  reg_addr_t                       addr,
`ifdef REGISTER_BYPASS_EN
    input  logic                            rst_n,
    input  logic                            write,
    input  reg_addr_t                       write_addr,
    input  reg_data_t                       write_data,
`endif
    output reg_data_t                       data
);

    reg_data_t stored;

    assign stored = regs[addr];

`ifdef REGISTER_BYPASS_EN
    // A pending write to the addressed word is forwarded before the edge;
    // a reset cycle discards the write, so it must not be forwarded either.
    logic bypass_hit;

    assign bypass_hit = rst_n && write && (write_addr == addr);
    assign data       = bypass_hit ? write_data : stored;
`else
    assign data = stored;
`endif

endmodule

// File: rtl/register.sv
// Register file: 16 x 16-bit words, one synchronous write port, two
// independent combinational read ports (A/B) feeding the ALU operand buses.
// Latency: write visible on reads right after the clk edge; reads are
// combinational. Backpressure: none, a write is accepted every cycle.
//
// Ports:
//   clk           rising-edge clock for all state
//   rst_n         synchronous active-low reset, clears every word, beats write
//   write         write enable
//   WriteAddress  destination index
//   WriteData     data to store
//   ReadAddrA/B   read indices for ports A and B
//   DataOutputA/B contents of the selected words
//
// Build option: define REGISTER_BYPASS_EN for write-through bypass on both
// read ports (the pending write data appears on a matching port before the
// edge). Left undefined, read ports show stored contents only.
module register
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      write,
    input  reg_addr_t WriteAddress,
    input  reg_data_t WriteData,
    input  reg_addr_t ReadAddrA,
    input  reg_addr_t ReadAddrB,
    output reg_data_t DataOutputA,
    output reg_data_t DataOutputB
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             word_en;

    // One-hot decode: each word compares its own index, so an unknown
    // address can only ever enable words that match, never corrupt others.
    always_comb begin
        word_en = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            word_en[i] = write && (WriteAddress == reg_addr_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (word_en[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    register_read_port u_port_a (
        .regs       (regs),
        .addr       (ReadAddrA),
`ifdef REGISTER_BYPASS_EN
        .rst_n      (rst_n),
        .write      (write),
        .write_addr (WriteAddress),
        .write_data (WriteData),
`endif
        .data       (DataOutputA)
    );

    register_read_port u_port_b (
        .regs       (regs),
        .addr       (ReadAddrB),
`ifdef REGISTER_BYPASS_EN
        .rst_n      (rst_n),
        .write      (write),
        .write_addr (WriteAddress),
        .write_data (WriteData),
`endif
        .data       (DataOutputB)
    );

endmodule

// File: tb/tb_register.sv
// Self-checking bench for the register file.
// Inputs change on the falling edge; outputs are sampled 1ns later, well
// away from the rising edge where state changes.
module tb_register;

    logic        clk;
    logic        rst_n;
    logic        write;
    logic [3:0]  WriteAddress;
    logic [15:0] WriteData;
    logic [3:0]  ReadAddrA;
    logic [3:0]  ReadAddrB;
    logic [15:0] DataOutputA;
    logic [15:0] DataOutputB;

    int n_cmp;
    int n_err;

    // Reference contents of the register file.
    logic [15:0] model [16];

    register dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write        (write),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .ReadAddrA    (ReadAddrA),
        .ReadAddrB    (ReadAddrB),
        .DataOutputA  (DataOutputA),
        .DataOutputB  (DataOutputB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value a read port should show right now, before the next edge.
    function automatic logic [15:0] expect_read(input logic [3:0] addr);
`ifdef REGISTER_BYPASS_EN
        if (rst_n && write && addr == WriteAddress) return WriteData;
`endif
        return model[addr];
    endfunction

    // Advance one rising edge, apply the same edge to the model, then
    // return to the falling edge where the next stimulus is driven.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        end else if (write) begin
            model[WriteAddress] = WriteData;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; write = 1'b1; WriteAddress = 4'd7; WriteData = 16'h1234;
        ReadAddrA = '0; ReadAddrB = '0;
        tick(); tick();
        rst_n = 1'b1; write = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ReadAddrA = 4'(i);
            ReadAddrB = 4'(15 - i);
            #1;
            n_cmp++;
            if (DataOutputA !== 16'h0000 || DataOutputB !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_sweep addr=%0d: A=%h B=%h required 0000/0000",
                         i, DataOutputA, DataOutputB);
            end
        end
    endtask

    task automatic test_basic_write();
        write = 1'b1; WriteAddress = 4'd5; WriteData = 16'h2025;
        tick();
        write = 1'b0;
        ReadAddrA = 4'd5;
        #1;
        n_cmp++;
        if (DataOutputA !== 16'h2025) begin
            n_err++;
            $display("FAIL basic_write: A=%h required 2025", DataOutputA);
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 5) continue;
            ReadAddrB = 4'(i);
            #1;
            n_cmp++;
            if (DataOutputB !== 16'h0000) begin
                n_err++;
                $display("FAIL basic_others addr=%0d: B=%h required 0000", i, DataOutputB);
            end
        end
    endtask

    task automatic test_second_port();
        write = 1'b1; WriteAddress = 4'd1; WriteData = 16'h5678;
        tick();
        write = 1'b0;
        ReadAddrA = 4'd5; ReadAddrB = 4'd1;
        #1;
        n_cmp++;
        if (DataOutputA !== 16'h2025 || DataOutputB !== 16'h5678) begin
            n_err++;
            $display("FAIL dual_read: A=%h B=%h required 2025/5678", DataOutputA, DataOutputB);
        end
        ReadAddrB = 4'd5;
        #1;
        n_cmp++;
        if (DataOutputA !== 16'h2025 || DataOutputB !== 16'h2025) begin
            n_err++;
            $display("FAIL same_addr: A=%h B=%h required 2025/2025", DataOutputA, DataOutputB);
        end
    endtask

    task automatic test_write_gating();
        write = 1'b0; WriteAddress = 4'd1; WriteData = 16'hFFFF;
        tick(); tick(); tick();
        ReadAddrB = 4'd1;
        #1;
        n_cmp++;
        if (DataOutputB !== 16'h5678) begin
            n_err++;
            $display("FAIL write_gating: B=%h required 5678", DataOutputB);
        end
    endtask

    task automatic test_read_during_write();
        logic [15:0] before_req;
`ifdef REGISTER_BYPASS_EN
        before_req = 16'hBEEF;
`else
        before_req = 16'h0000;
`endif
        ReadAddrA = 4'd3;
        write = 1'b1; WriteAddress = 4'd3; WriteData = 16'hBEEF;
        #1;
        n_cmp++;
        if (DataOutputA !== before_req) begin
            n_err++;
            $display("FAIL rdw_before_edge: A=%h required %h", DataOutputA, before_req);
        end
        tick();
        write = 1'b0;
        #1;
        n_cmp++;
        if (DataOutputA !== 16'hBEEF) begin
            n_err++;
            $display("FAIL rdw_after_edge: A=%h required beef", DataOutputA);
        end
    endtask

    task automatic test_reset_priority();
        rst_n = 1'b0; write = 1'b1; WriteAddress = 4'd5; WriteData = 16'h1234;
        ReadAddrA = 4'd5; ReadAddrB = 4'd1;
        // Bypass must be suppressed while reset is low.
        #1;
        n_cmp++;
        if (DataOutputA !== 16'h2025) begin
            n_err++;
            $display("FAIL reset_no_bypass: A=%h required 2025", DataOutputA);
        end
        tick();
        rst_n = 1'b1; write = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ReadAddrA = 4'(i);
            ReadAddrB = 4'(i);
            #1;
            n_cmp++;
            if (DataOutputA !== 16'h0000 || DataOutputB !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_priority addr=%0d: A=%h B=%h required 0000/0000",
                         i, DataOutputA, DataOutputB);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ea, eb;
        for (int c = 0; c < 200; c++) begin
            write        = 1'($urandom_range(0, 1));
            WriteAddress = 4'($urandom_range(0, 15));
            WriteData    = 16'($urandom);
            ReadAddrA    = 4'($urandom_range(0, 15));
            // Bias B toward the write address to exercise read-during-write.
            ReadAddrB    = ($urandom_range(0, 3) == 0) ? WriteAddress
                                                       : 4'($urandom_range(0, 15));
            #1;
            ea = expect_read(ReadAddrA);
            eb = expect_read(ReadAddrB);
            n_cmp++;
            if (DataOutputA !== ea || DataOutputB !== eb) begin
                n_err++;
                $display("FAIL random cyc=%0d ra=%0d rb=%0d: A=%h B=%h required %h/%h",
                         c, ReadAddrA, ReadAddrB, DataOutputA, DataOutputB, ea, eb);
            end
            tick();
        end
        // Final sweep of the whole array against the model.
        write = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ReadAddrA = 4'(i);
            ReadAddrB = 4'(15 - i);
            #1;
            n_cmp++;
            if (DataOutputA !== model[i] || DataOutputB !== model[15 - i]) begin
                n_err++;
                $display("FAIL random_sweep addr=%0d: A=%h B=%h required %h/%h",
                         i, DataOutputA, DataOutputB, model[i], model[15 - i]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        rst_n = 1'b0; write = 1'b0; WriteAddress = '0; WriteData = '0;
        ReadAddrA = '0; ReadAddrB = '0;
        @(negedge clk);

        test_reset();
        test_basic_write();
        test_second_port();
        test_write_gating();
        test_read_during_write();
        test_reset_priority();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
